// File: rtl/operand_bypass_net.sv
// operand_bypass_net
//
// Operand bypass network between register-file read and a consumer stage.
// Each read port resolves its register number against NUM_SRC in-flight
// producers (index 0 youngest, highest priority). A match whose result is
// not final yet raises a per-port hazard stall. While the consumer stage is
// held, each port captures its resolved operand once it is available, so
// producers draining out of the pipe cannot change it.
//
// Ports:
//   aclk, aresetn   clock (rising edge), asynchronous active-low reset
//   port_addr       register number per port, port p in slice p
//   port_use        operand is consumed (gates the stall only)
//   port_rf_data    register-file read value per port
//   src_wen/rd/data/ready  producer write enable, destination, result, final
//   hold            consumer stage stalled, operands must stay stable
//   flush           consumer stage contents killed
//   opnd_data       resolved operand per port
//   port_stall      per-port hazard, stall is their OR
//
// Handshake: there is no valid/ready pair here. A port is "pending" when its
// winning producer has src_ready=0; the consumer may only advance while
// stall=0. During hold, a non-pending port is frozen at the next edge.

module operand_bypass_net #(
    parameter int NUM_PORTS = 3,
    parameter int NUM_SRC   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS-1:0]          port_use,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_rf_data,
    input  logic [NUM_SRC-1:0]            src_wen,
    input  logic [NUM_SRC*ADDR_W-1:0]     src_rd,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_ready,
    input  logic                          hold,
    input  logic                          flush,
    output logic [NUM_PORTS*DATA_W-1:0]   opnd_data,
    output logic [NUM_PORTS-1:0]          port_stall,
    output logic                          stall
);

    typedef enum logic {
        EMPTY    = 1'b0,
        CAPTURED = 1'b1
    } cap_state_t;

    // Per-port capture FSM state, readable hierarchically for checkers.
    cap_state_t        state    [NUM_PORTS];
    logic [DATA_W-1:0] cap_data [NUM_PORTS];
    logic [DATA_W-1:0] live_data[NUM_PORTS];
    logic [NUM_PORTS-1:0] pending;

    // Live resolution. The first matching source in index order wins, and
    // once it has won an older ready source can no longer override it.
    always_comb begin : resolve
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] rd;
        logic              hit;
        addr = '0;
        rd   = '0;
        hit  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr         = port_addr[p*ADDR_W +: ADDR_W];
            hit          = 1'b0;
            live_data[p] = port_rf_data[p*DATA_W +: DATA_W];
            pending[p]   = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                rd = src_rd[s*ADDR_W +: ADDR_W];
                if (!hit && src_wen[s] && (rd != '0) && (rd == addr)) begin
                    hit          = 1'b1;
                    live_data[p] = src_data[s*DATA_W +: DATA_W];
                    pending[p]   = ~src_ready[s];
                end
            end
            // Register 0 reads as zero regardless of the register-file value.
            if (addr == '0) begin
                live_data[p] = '0;
                pending[p]   = 1'b0;
            end
        end
    end

    // Capture FSM per port. flush wins over hold; a pending port retries
    // every held cycle until its producer reports ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p]    <= EMPTY;
                cap_data[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (flush) begin
                    state[p] <= EMPTY;
                end else begin
                    case (state[p])
                        EMPTY: begin
                            if (hold && !pending[p]) begin
                                state[p]    <= CAPTURED;
                                cap_data[p] <= live_data[p];
                            end
                        end
                        CAPTURED: begin
                            if (!hold) state[p] <= EMPTY;
                        end
                        default: state[p] <= EMPTY;
                    endcase
                end
            end
        end
    end

    always_comb begin
        opnd_data  = '0;
        port_stall = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state[p] == CAPTURED) begin
                opnd_data[p*DATA_W +: DATA_W] = cap_data[p];
                port_stall[p]                 = 1'b0;
            end else begin
                opnd_data[p*DATA_W +: DATA_W] = live_data[p];
                port_stall[p]                 = pending[p] & port_use[p];
            end
        end
    end

    assign stall = |port_stall;

endmodule

// File: tb/tb_operand_bypass_net.sv
// Bench for operand_bypass_net: directed scenarios followed by random
// traffic, checked against a behavioural model of the forwarding rules.

module tb_operand_bypass_net;

    localparam int NP = 3;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- stimulus variables ----------------
    logic [AW-1:0] addr_a [NP];
    logic          use_a  [NP];
    logic [DW-1:0] rf_a   [NP];
    logic          wen_a  [NS];
    logic [AW-1:0] rd_a   [NS];
    logic [DW-1:0] sdat_a [NS];
    logic          rdy_a  [NS];
    logic          hold;
    logic          flush;

    logic [NP*AW-1:0] port_addr;
    logic [NP-1:0]    port_use;
    logic [NP*DW-1:0] port_rf_data;
    logic [NS-1:0]    src_wen;
    logic [NS*AW-1:0] src_rd;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_ready;
    logic [NP*DW-1:0] opnd_data;
    logic [NP-1:0]    port_stall;
    logic             stall;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            port_addr[p*AW +: AW]    = addr_a[p];
            port_use[p]              = use_a[p];
            port_rf_data[p*DW +: DW] = rf_a[p];
        end
        for (int s = 0; s < NS; s++) begin
            src_wen[s]           = wen_a[s];
            src_rd[s*AW +: AW]   = rd_a[s];
            src_data[s*DW +: DW] = sdat_a[s];
            src_ready[s]         = rdy_a[s];
        end
    end

    operand_bypass_net #(
        .NUM_PORTS(NP), .NUM_SRC(NS), .DATA_W(DW), .ADDR_W(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .port_addr(port_addr), .port_use(port_use), .port_rf_data(port_rf_data),
        .src_wen(src_wen), .src_rd(src_rd), .src_data(src_data),
        .src_ready(src_ready), .hold(hold), .flush(flush),
        .opnd_data(opnd_data), .port_stall(port_stall), .stall(stall)
    );

    // ---------------- reference model ----------------
    bit            frz   [NP];   // operand frozen for the held instruction
    logic [DW-1:0] frz_v [NP];

    int n_checks = 0;
    int n_fail   = 0;

    // Value a port reads right now from the live pipeline, and whether the
    // youngest producer of that register has not finished yet.
    task automatic model_live(input int p, output logic [DW-1:0] v, output bit pend);
        v    = rf_a[p];
        pend = 0;
        if (addr_a[p] == 0) begin
            v = '0;
            return;
        end
        for (int s = 0; s < NS; s++) begin
            if (wen_a[s] && rd_a[s] != 0 && rd_a[s] == addr_a[p]) begin
                v    = sdat_a[s];
                pend = !rdy_a[s];
                return;
            end
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] v;
        bit pend;
        for (int p = 0; p < NP; p++) begin
            model_live(p, v, pend);
            if (flush)           frz[p] = 0;
            else if (frz[p])     frz[p] = hold;
            else if (hold && !pend) begin
                frz[p]   = 1;
                frz_v[p] = v;
            end
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            frz[p]   = 0;
            frz_v[p] = '0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input int p,
                       input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s port%0d got=%h expected=%h", tag, p, got, exp);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] v;
        bit pend;
        logic exp_or;
        exp_or = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (frz[p]) begin
                chk("data_frozen", p, opnd_data[p*DW +: DW], frz_v[p]);
                chk("stall_frozen", p, DW'(port_stall[p]), '0);
            end else begin
                model_live(p, v, pend);
                if (!pend) chk("data_live", p, opnd_data[p*DW +: DW], v);
                chk("stall_live", p, DW'(port_stall[p]), DW'(pend && use_a[p]));
                exp_or |= pend && use_a[p];
            end
        end
        chk("stall_or", 0, DW'(stall), DW'(exp_or));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin
            addr_a[p] = '0; use_a[p] = 1'b0; rf_a[p] = '0;
        end
        for (int s = 0; s < NS; s++) begin
            wen_a[s] = 1'b0; rd_a[s] = '0; sdat_a[s] = '0; rdy_a[s] = 1'b0;
        end
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_src(input int s, input bit w, input int rd,
                           input logic [DW-1:0] d, input bit r);
        wen_a[s] = w; rd_a[s] = AW'(rd); sdat_a[s] = d; rdy_a[s] = r;
    endtask

    // Check mid-cycle, then advance the model and the DUT through one edge.
    task automatic cycle();
        @(negedge aclk);
        check_all();
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int p = 0; p < NP; p++) begin
            addr_a[p] = AW'($urandom_range(0, 7));
            use_a[p]  = 1'($urandom_range(0, 1));
            rf_a[p]   = $urandom;
        end
        for (int s = 0; s < NS; s++) begin
            wen_a[s]  = ($urandom_range(0, 3) != 0);
            rd_a[s]   = AW'($urandom_range(0, 7));
            sdat_a[s] = $urandom;
            rdy_a[s]  = ($urandom_range(0, 3) != 0);
        end
        hold  = ($urandom_range(0, 9) < 4);
        flush = ($urandom_range(0, 19) == 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        clear_inputs();
        model_reset();
        #12;
        // Reset state: everything zero, no stall.
        check_all();
        chk("reset_stall", 0, DW'(stall), '0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Priority: youngest wins, then older, then register file.
        addr_a[0] = 5; rf_a[0] = 32'hCCCC0003;
        set_src(0, 1, 5, 32'hAAAA0001, 1);
        set_src(1, 1, 5, 32'hBBBB0002, 1);
        #1 chk("prio_src0", 0, opnd_data[0 +: DW], 32'hAAAA0001);
        cycle();
        wen_a[0] = 0;
        #1 chk("prio_src1", 0, opnd_data[0 +: DW], 32'hBBBB0002);
        cycle();
        wen_a[1] = 0;
        #1 chk("prio_rf", 0, opnd_data[0 +: DW], 32'hCCCC0003);
        cycle();

        // Zero register ignores a producer writing r0.
        clear_inputs();
        addr_a[1] = 0; rf_a[1] = 32'hDEAD0000;
        set_src(0, 1, 0, 32'h1234, 1);
        #1 chk("zero_data", 1, opnd_data[DW +: DW], '0);
        cycle();

        // Load-use: younger not-ready match beats older ready one.
        clear_inputs();
        addr_a[2] = 7; use_a[2] = 1;
        set_src(0, 1, 7, 32'h1, 0);
        set_src(1, 1, 7, 32'h2, 1);
        #1 chk("loaduse_stall", 2, DW'(stall), 1);
        cycle();
        use_a[2] = 0;
        #1 chk("loaduse_nouse", 2, DW'(stall), 0);
        cycle();

        // Hold capture across a draining producer.
        clear_inputs();
        addr_a[0] = 3; hold = 1;
        set_src(1, 1, 3, 32'h55, 1);
        cycle();
        wen_a[1] = 0; rf_a[0] = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_frozen", 0, opnd_data[0 +: DW], 32'h55);
            cycle();
        end
        hold = 0;
        cycle();  // held instruction consumes its frozen operand this cycle
        #1 chk("hold_release", 0, opnd_data[0 +: DW], 32'h99);
        cycle();

        // Pending during hold captures when the load returns.
        clear_inputs();
        addr_a[0] = 4; use_a[0] = 1; hold = 1; rf_a[0] = 32'h11;
        set_src(0, 1, 4, 32'h0, 0);
        for (int i = 0; i < 2; i++) begin
            #1 chk("pend_stall", 0, DW'(stall), 1);
            cycle();
        end
        set_src(0, 1, 4, 32'h77, 1);
        cycle();
        wen_a[0] = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("pend_frozen", 0, opnd_data[0 +: DW], 32'h77);
            cycle();
        end
        hold = 0;
        cycle();
        cycle();

        // Flush overrides hold.
        clear_inputs();
        addr_a[0] = 3; hold = 1;
        set_src(1, 1, 3, 32'h55, 1);
        cycle();
        wen_a[1] = 0; rf_a[0] = 32'h99; flush = 1;
        cycle();
        flush = 0;
        #1 chk("flush_live", 0, opnd_data[0 +: DW], 32'h99);
        cycle();

        // Asynchronous reset mid-hold discards the captured value.
        clear_inputs();
        addr_a[0] = 3; hold = 1;
        set_src(1, 1, 3, 32'h55, 1);
        cycle();
        wen_a[1] = 0; rf_a[0] = 32'h99;
        #1 aresetn = 1'b0;
        model_reset();
        #1 chk("reset_live", 0, opnd_data[0 +: DW], 32'h99);
        check_all();
        #1 aresetn = 1'b1;
        cycle();
        hold = 0;
        cycle();

        // Random traffic with small register numbers to force collisions.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_bypass_net.md
# operand_bypass_net

Parametrised operand bypass network between the register-file read stage and a consumer pipeline stage. It resolves each of NUM_PORTS source operands against NUM_SRC in-flight producer stages, with the youngest producer taking priority. It raises a per-port hazard stall when the matching producer's data is not yet available, for example a load still in MEM. It also captures resolved operands while the consumer stage is held, for example during multi-cycle divide, so drained producers cannot corrupt them.

## Interface
Parameters:
- NUM_PORTS, 3, number of operand read ports
- NUM_SRC, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
- DATA_W, 32, operand width
- ADDR_W, 5, register-number width; register 0 is hard-wired zero

Ports:
- aclk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- port_addr  in  NUM_PORTS*ADDR_W  register number per port (port p in slice p)
- port_use  in  NUM_PORTS  port operand is consumed; gates stall only
- port_rf_data  in  NUM_PORTS*DATA_W  register-file read value per port
- src_wen  in  NUM_SRC  source s will write a register
- src_rd  in  NUM_SRC*ADDR_W  destination register of source s
- src_data  in  NUM_SRC*DATA_W  result of source s
- src_ready  in  NUM_SRC  src_data is final (0 for an outstanding load)
- hold  in  1  consumer stage is stalled; operands must remain stable
- flush  in  1  consumer stage contents are killed
- opnd_data  out  NUM_PORTS*DATA_W  resolved operand per port
- port_stall  out  NUM_PORTS  per-port hazard
- stall  out  1  OR of port_stall

## Operation
Source match:
- Source s matches port p when src_wen[s]=1, src_rd[s]!=0 and src_rd[s]==port_addr[p].

Combinational resolution per port, in EMPTY state:
- port_addr==0: value 0, no stall.
- Otherwise select the lowest-index matching source s.
  - If src_ready[s]=1, value is src_data[s].
  - If src_ready[s]=0, value is don't-care and port_stall[p]=port_use[p].
- If no source matches, value is port_rf_data[p].
- An older ready source never overrides a younger not-ready match.

Per-port capture FSM, states EMPTY and CAPTURED:
- flush=1 at an edge: all ports go to EMPTY. flush has priority over hold.
- EMPTY, hold=1, port not pending: capture the resolved value, go to CAPTURED. Pending means the winning match has src_ready=0.
- EMPTY, hold=1, port pending: stay EMPTY and retry each cycle.
- EMPTY, hold=0: stay EMPTY.
- CAPTURED, hold=1: stay; the value is frozen.
- CAPTURED, hold=0: go to EMPTY.

Output in CAPTURED:
- opnd_data[p] is the captured value, ignoring all sources and port_rf_data.
- port_stall[p]=0.

Capture does not depend on port_use.

## Timing
- Resolution is combinational with zero latency: opnd_data and port_stall follow inputs in the same cycle while EMPTY.
- Capture takes effect at the rising edge of aclk. The captured value is visible from the cycle after the capturing edge.
- Reset:
  - asserting aresetn low forces every port to EMPTY immediately and asynchronously; capture registers are cleared to 0;
  - outputs are then purely combinational from inputs, so with all src_wen=0 and port_addr=0, opnd_data=0 and stall=0;
  - reset asserted mid-hold discards captured values.
- The first cycle of hold uses the live resolved value; subsequent hold cycles use the captured value.
- A pending port during hold captures on the first edge at which its winning source reports ready.
- hold deasserting and a new instruction arriving occur at the same edge: the FSM goes to EMPTY and the new operands are resolved live in that next cycle.
- Same-edge flush and hold: go to EMPTY.

## Test plan
- Priority: port0 addr=5; src0 (wen=1, rd=5, data=0xAAAA0001, ready=1); src1 (rd=5, data=0xBBBB0002, ready=1) -> opnd_data[0]=0xAAAA0001, stall=0. With src0 wen=0 -> 0xBBBB0002. With no match -> port_rf_data.
- Zero register: port1 addr=0, src0 rd=0 wen=1 data=0x1234 -> opnd_data[1]=0, port_stall[1]=0.
- Load-use: port2 addr=7 use=1, src0 rd=7 ready=0, src1 rd=7 ready=1 -> port_stall[2]=1, stall=1. With use=0 -> stall=0.
- Hold capture: port0 addr=3 forwarded from src1 data=0x55 and hold=1 for 4 cycles; from cycle 2, src1 wen=0 and port_rf_data=0x99 -> opnd_data[0]=0x55 for all 4 cycles; after hold=0, it equals 0x99.
- Pending during hold: hold=1, src0 rd=4 ready=0 for 2 cycles, then ready=1 data=0x77, then src0 wen=0 -> stall high for 2 cycles, then opnd_data=0x77 frozen until hold=0.
- Flush and reset: port CAPTURED with 0x55; flush=1 with hold=1 -> next cycle is live resolution. Async aresetn pulse mid-hold -> immediately live resolution, captured value gone.
